wb_select_reg: RTL and testbench

Parametrised writeback-select stage of the CPU datapath, successor to the 2:1 writeback mux. Each cycle it picks one of `NSRC` result sources (ALU result, memory load data, link address, upper immediate, …), aligns and extends sub-word loads, and captures the result in a one-cycle MEM/WB pipeline register. The registered outputs drive the register-file write port and the forwarding path. The block also keeps a retired-instruction counter.

---
 rtl/wb_select_reg_pkg.sv | 30 +++
 rtl/wb_select_reg_load_align.sv | 39 +++
 rtl/wb_select_reg.sv | 115 +++++++++++
 tb/tb_wb_select_reg.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_select_reg_pkg.sv
// ----------------------------------------------------------------------------
// wb_select_reg_pkg : shared CPU constants for writeback select / load align
// Revision 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package wb_select_reg_pkg;

  localparam logic [1:0] LD_BYTE = 2'd0;
  localparam logic [1:0] LD_HALF = 2'd1;
  localparam logic [1:0] LD_WORD = 2'd2;

  localparam int WB_SRC_ALU  = 0;
  localparam int WB_SRC_MEM  = 1;
  localparam int WB_SRC_LINK = 2;
  localparam int WB_SRC_LUI  = 3;

  // Widen a byte (low 8 bits of lane) or a half lane to 32 bits.
  function automatic logic [31:0] ext_lane(input logic [15:0] lane,
                                           input logic        is_half,
                                           input logic        is_unsigned);
    logic [31:0] r;
    if (is_half) r = {{16{!is_unsigned & lane[15]}}, lane};
    else         r = {{24{!is_unsigned & lane[7]}}, lane[7:0]};
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/wb_select_reg_load_align.sv
// ----------------------------------------------------------------------------
// load_align : little-endian sub-word load extraction and misalign detection
// Revision 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module load_align
  import wb_select_reg_pkg::*;
(
  input  logic [31:0] data_i,
  input  logic [1:0]  ld_size_i,
  input  logic        ld_unsigned_i,
  input  logic [1:0]  addr_lo_i,
  output logic [31:0] data_o,
  output logic        misalign_o
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte     = data_i[{addr_lo_i, 3'b000} +: 8];
    w_half     = addr_lo_i[1] ? data_i[31:16] : data_i[15:0];
    data_o     = data_i;
    misalign_o = 1'b0;
    case (ld_size_i)
      LD_BYTE: data_o = ext_lane({8'h00, w_byte}, 1'b0, ld_unsigned_i);
      LD_HALF: begin
        data_o     = ext_lane(w_half, 1'b1, ld_unsigned_i);
        misalign_o = addr_lo_i[0];
      end
      // Sizes 2 and 3 are both full-word loads.
      default: misalign_o = |addr_lo_i;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/wb_select_reg.sv
// ----------------------------------------------------------------------------
// wb_select_reg : N-way writeback select, MEM/WB register and retire counter
// Revision 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module wb_select_reg
  import wb_select_reg_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int NSRC    = 4,
  parameter int SEL_W   = $clog2(NSRC),
  parameter int MEM_SRC = WB_SRC_MEM,
  parameter int RADDR_W = 5,
  parameter int CNT_W   = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   stall,
  input  logic                   flush,
  input  logic [NSRC*DATA_W-1:0] src_data,
  input  logic [SEL_W-1:0]       src_sel,
  input  logic [1:0]             ld_size,
  input  logic                   ld_unsigned,
  input  logic [1:0]             addr_lo,
  input  logic                   rd_we,
  input  logic [RADDR_W-1:0]     rd_addr,
  output logic                   wb_valid,
  output logic                   wb_we,
  output logic [RADDR_W-1:0]     wb_addr,
  output logic [DATA_W-1:0]      wb_data,
  output logic                   wb_misalign,
  output logic [CNT_W-1:0]       retire_cnt
);

  logic              w_acc;
  logic              w_is_mem;
  logic [DATA_W-1:0] w_sel_data;
  logic [DATA_W-1:0] w_aligned;
  logic              w_mis_raw;
  logic [DATA_W-1:0] w_data;
  logic              w_mis;
  logic              w_we;

  logic               valid_q, valid_d;
  logic               we_q,    we_d;
  logic               mis_q,   mis_d;
  logic [RADDR_W-1:0] addr_q,  addr_d;
  logic [DATA_W-1:0]  data_q,  data_d;
  logic [CNT_W-1:0]   cnt_q,   cnt_d;

  assign in_ready = !stall;
  assign w_acc    = in_valid & !stall & !flush;
  assign w_is_mem = (src_sel == SEL_W'(MEM_SRC));

  // Selects beyond NSRC match no source and yield zero.
  always_comb begin
    w_sel_data = '0;
    for (int k = 0; k < NSRC; k++) begin
      if (src_sel == SEL_W'(k)) w_sel_data = src_data[k*DATA_W +: DATA_W];
    end
  end

  load_align u_load_align (
    .data_i        (w_sel_data),
    .ld_size_i     (ld_size),
    .ld_unsigned_i (ld_unsigned),
    .addr_lo_i     (addr_lo),
    .data_o        (w_aligned),
    .misalign_o    (w_mis_raw)
  );

  assign w_data = w_is_mem ? w_aligned : w_sel_data;
  assign w_mis  = w_is_mem & w_mis_raw;
  assign w_we   = rd_we & (rd_addr != '0) & !w_mis;

  always_comb begin
    valid_d = w_acc;
    we_d    = w_acc & w_we;
    mis_d   = w_acc & w_mis;
    addr_d  = w_acc ? rd_addr : addr_q;
    data_d  = w_acc ? w_data  : data_q;
    cnt_d   = cnt_q + CNT_W'(valid_q);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      we_q    <= 1'b0;
      mis_q   <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      cnt_q   <= '0;
    end else begin
      valid_q <= valid_d;
      we_q    <= we_d;
      mis_q   <= mis_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
    end
  end

  assign wb_valid    = valid_q;
  assign wb_we       = we_q;
  assign wb_misalign = mis_q;
  assign wb_addr     = addr_q;
  assign wb_data     = data_q;
  assign retire_cnt  = cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_wb_select_reg.sv
// ----------------------------------------------------------------------------
// tb_wb_select_reg : directed bench with a cycle model of the writeback stage
// Revision 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_wb_select_reg;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic         stall;
  logic         flush;
  logic [127:0] src_data;
  logic [2:0]   src_sel;
  logic [1:0]   ld_size;
  logic         ld_unsigned;
  logic [1:0]   addr_lo;
  logic         rd_we;
  logic [4:0]   rd_addr;
  logic         wb_valid;
  logic         wb_we;
  logic [4:0]   wb_addr;
  logic [31:0]  wb_data;
  logic         wb_misalign;
  logic [3:0]   retire_cnt;

  int n_vec = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  // Three select bits let the bench reach out-of-range selects with NSRC = 4.
  wb_select_reg #(
    .DATA_W(32), .NSRC(4), .SEL_W(3), .MEM_SRC(1), .RADDR_W(5), .CNT_W(4)
  ) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .stall(stall), .flush(flush), .src_data(src_data), .src_sel(src_sel),
    .ld_size(ld_size), .ld_unsigned(ld_unsigned), .addr_lo(addr_lo),
    .rd_we(rd_we), .rd_addr(rd_addr), .wb_valid(wb_valid), .wb_we(wb_we),
    .wb_addr(wb_addr), .wb_data(wb_data), .wb_misalign(wb_misalign),
    .retire_cnt(retire_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Returns {misalign, data} from the writeback rules using integer arithmetic.
  function automatic logic [32:0] expect_wb(input int sel, input logic [127:0] srcs,
                                            input int size, input bit uns, input int alo);
    longint      v;
    bit          mis;
    logic [31:0] raw;
    mis = 1'b0;
    if (sel >= 4) begin
      v = 0;
    end else begin
      raw = srcs[sel*32 +: 32];
      v   = longint'(raw);
      if (sel == 1) begin
        if (size == 0) begin
          v = longint'(raw >> (8 * alo)) % 256;
          if (!uns && v >= 128) v = v - 256;
        end else if (size == 1) begin
          v = longint'(raw >> (16 * (alo / 2))) % 65536;
          if (!uns && v >= 32768) v = v - 65536;
          mis = (alo % 2) == 1;
        end else begin
          mis = alo != 0;
        end
      end
    end
    return {mis, v[31:0]};
  endfunction

  logic        m_valid, m_we, m_mis;
  logic [4:0]  m_addr;
  logic [31:0] m_data;
  int          m_cnt;

  always @(posedge clk) begin
    logic [32:0] r;
    if (!rst_n) begin
      m_valid <= 1'b0; m_we <= 1'b0; m_mis <= 1'b0;
      m_addr  <= '0;   m_data <= '0; m_cnt <= 0;
    end else begin
      m_cnt <= (m_cnt + (m_valid ? 1 : 0)) % 16;
      if (in_valid && !stall && !flush) begin
        r = expect_wb(int'(src_sel), src_data, int'(ld_size), ld_unsigned, int'(addr_lo));
        m_valid <= 1'b1;
        m_mis   <= r[32];
        m_data  <= r[31:0];
        m_addr  <= rd_addr;
        m_we    <= rd_we && (rd_addr != 0) && !r[32];
      end else begin
        m_valid <= 1'b0; m_we <= 1'b0; m_mis <= 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("cyc_valid",    32'(wb_valid),    32'(m_valid));
      chk("cyc_we",       32'(wb_we),       32'(m_we));
      chk("cyc_misalign", 32'(wb_misalign), 32'(m_mis));
      chk("cyc_addr",     32'(wb_addr),     32'(m_addr));
      chk("cyc_data",     wb_data,          m_data);
      chk("cyc_cnt",      32'(retire_cnt),  32'(m_cnt));
      chk("cyc_in_ready", 32'(in_ready),    32'(!stall));
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic issue(input logic [2:0] sel, input logic [1:0] sz, input logic u,
                       input logic [1:0] al, input logic we, input logic [4:0] rd);
    in_valid = 1'b1; src_sel = sel; ld_size = sz; ld_unsigned = u;
    addr_lo = al; rd_we = we; rd_addr = rd;
  endtask

  initial begin
    logic [3:0] c;
    logic [3:0] need;
    int         pulses;

    rst_n = 1'b0; in_valid = 1'b1; stall = 1'b0; flush = 1'b0;
    src_data = {32'h0000_0000, 32'hCAFE_0000, 32'h80FF_7F01, 32'h1234_5678};
    src_sel = 3'd0; ld_size = 2'd2; ld_unsigned = 1'b0; addr_lo = 2'd0;
    rd_we = 1'b1; rd_addr = 5'd7;
    step();
    chk_en = 1'b1;
    step();
    chk("rst_valid", 32'(wb_valid), 32'd0);
    chk("rst_we",    32'(wb_we), 32'd0);
    chk("rst_mis",   32'(wb_misalign), 32'd0);
    chk("rst_addr",  32'(wb_addr), 32'd0);
    chk("rst_data",  wb_data, 32'd0);
    chk("rst_cnt",   32'(retire_cnt), 32'd0);

    rst_n = 1'b1; in_valid = 1'b0;
    step();

    issue(3'd0, 2'd2, 1'b0, 2'd0, 1'b1, 5'd3);
    step();
    chk("alu_valid", 32'(wb_valid), 32'd1);
    chk("alu_we",    32'(wb_we), 32'd1);
    chk("alu_addr",  32'(wb_addr), 32'd3);
    chk("alu_data",  wb_data, 32'h1234_5678);
    in_valid = 1'b0;
    step();
    chk("alu_valid_drop", 32'(wb_valid), 32'd0);

    issue(3'd1, 2'd0, 1'b0, 2'd2, 1'b1, 5'd4);
    step();
    chk("ld_b_s_a2", wb_data, 32'hFFFF_FFFF);
    issue(3'd1, 2'd0, 1'b1, 2'd1, 1'b1, 5'd5);
    step();
    chk("ld_b_u_a1", wb_data, 32'h0000_007F);
    issue(3'd1, 2'd1, 1'b0, 2'd2, 1'b1, 5'd6);
    step();
    chk("ld_h_s_a2", wb_data, 32'hFFFF_80FF);
    chk("ld_h_mis",  32'(wb_misalign), 32'd0);
    in_valid = 1'b0;
    step();

    c = retire_cnt;
    issue(3'd1, 2'd2, 1'b0, 2'd1, 1'b1, 5'd8);
    step();
    chk("misw_mis",  32'(wb_misalign), 32'd1);
    chk("misw_we",   32'(wb_we), 32'd0);
    chk("misw_data", wb_data, 32'h80FF_7F01);
    in_valid = 1'b0;
    step();
    chk("misw_cnt", 32'(retire_cnt), 32'(4'(c + 4'd1)));

    issue(3'd0, 2'd2, 1'b0, 2'd0, 1'b1, 5'd0);
    step();
    chk("r0_we",    32'(wb_we), 32'd0);
    chk("r0_valid", 32'(wb_valid), 32'd1);
    issue(3'd5, 2'd2, 1'b0, 2'd0, 1'b1, 5'd9);
    step();
    chk("sel5_data", wb_data, 32'd0);
    chk("sel5_we",   32'(wb_we), 32'd1);
    in_valid = 1'b0;
    step();

    c = retire_cnt;
    pulses = 0;
    issue(3'd2, 2'd2, 1'b0, 2'd0, 1'b1, 5'd10);
    step(); pulses += int'(wb_valid);
    stall = 1'b1;
    step(); pulses += int'(wb_valid);
    stall = 1'b0; flush = 1'b1;
    step(); pulses += int'(wb_valid);
    flush = 1'b0;
    step(); pulses += int'(wb_valid);
    in_valid = 1'b0;
    step(); pulses += int'(wb_valid);
    step(); pulses += int'(wb_valid);
    chk("sf_pulses", 32'(pulses), 32'd2);
    chk("sf_cnt", 32'(retire_cnt), 32'(4'(c + 4'd2)));

    need = 4'd15 - retire_cnt;
    for (int i = 0; i < int'(need); i++) begin
      issue(3'd3, 2'd2, 1'b0, 2'd0, 1'b1, 5'd11);
      step();
    end
    in_valid = 1'b0;
    step();
    step();
    chk("wrap_pre", 32'(retire_cnt), 32'd15);
    issue(3'd0, 2'd2, 1'b0, 2'd0, 1'b1, 5'd11);
    step();
    in_valid = 1'b0;
    step();
    chk("wrap_zero", 32'(retire_cnt), 32'd0);

    issue(3'd0, 2'd2, 1'b0, 2'd0, 1'b1, 5'd12);
    step();
    chk("mid_pre_valid", 32'(wb_valid), 32'd1);
    rst_n = 1'b0;
    step();
    chk("mid_rst_valid", 32'(wb_valid), 32'd0);
    chk("mid_rst_data",  wb_data, 32'd0);
    rst_n = 1'b1; in_valid = 1'b0;
    step();
    chk("mid_rst_cnt", 32'(retire_cnt), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
